// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store path: op fields, entry states, exception bits.
package lsu_pkg;

  localparam int OP_W      = 4;
  localparam int OP_STORE  = 3;
  localparam int OP_SIGNED = 2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    WAIT_REQ  = 2'd0,
    WAIT_RESP = 2'd1,
    DONE      = 2'd2
  } ent_state_e;

  localparam int EXCP_W        = 4;
  localparam int EXCP_LD_MIS   = 0;
  localparam int EXCP_ST_MIS   = 1;
  localparam int EXCP_LD_FAULT = 2;
  localparam int EXCP_ST_FAULT = 3;

  localparam int RESP_FAULT = 1;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  // Byte strobe for an access at lane 0; shifted by the address offset later.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects byte/half at the address offset and extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [OP_W-1:0] op,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;
  logic            sext;
  logic            unused_op;

  assign unused_op = op[OP_STORE];
  assign sext      = op[OP_SIGNED];

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    result  = shifted;
    case (op[1:0])
      SZ_B:    result = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
      SZ_H:    result = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_oq.sv
// In-order load/store queue between EXU and WBU with up to DEPTH outstanding bus requests.
// Optional perf counters are enabled by defining LSU_OQ_PERF_EN.
module lsu_oq
  import lsu_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 86,
  parameter int XLEN      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  input  logic [OP_W-1:0]      in_op_i,
  input  logic                 in_mem_i,
  input  logic [XLEN-1:0]      in_addr_i,
  input  logic [XLEN-1:0]      in_data_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [XLEN-1:0]      req_addr_o,
  output logic                 req_we_o,
  output logic [XLEN-1:0]      req_wdata_o,
  output logic [3:0]           req_wstrb_o,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o,
  input  logic [XLEN-1:0]      resp_rdata_i,
  input  logic [1:0]           resp_err_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [XLEN-1:0]      out_result_o,
  output logic [EXCP_W-1:0]    out_excp_o
`ifdef LSU_OQ_PERF_EN
  ,
  output logic [31:0]          perf_load_o,
  output logic [31:0]          perf_store_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [EXCP_W-1:0] excp;
  } ent_t;

  ent_t                 ent_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  ent_state_e           st_q  [DEPTH];

  logic [PW-1:0] head_q, iss_q, tail_q, drain_q;
  logic          active_q;

  logic [AW-1:0] hidx, iidx, tidx, rsp_idx;
  logic [PW-1:0] cnt, nwait;
  logic          full, iss_pend, iss_skip;
  logic          accept, acc_mis;
  logic [XLEN-1:0]   acc_data;
  logic [EXCP_W-1:0] acc_excp;
  logic          req_fire, resp_fire, drop, rsp_hit, rsp_done, resp_used;
  logic [XLEN-1:0] ld_result;
  logic            unused_err;

  assign unused_err = resp_err_i[0];

  assign hidx = head_q[AW-1:0];
  assign iidx = iss_q[AW-1:0];
  assign tidx = tail_q[AW-1:0];
  assign cnt  = tail_q - head_q;
  assign full = cnt == PW'(DEPTH);

  assign in_ready_o   = active_q && !full;
  assign resp_ready_o = active_q;
  assign accept       = in_valid_i && in_ready_o && !flush_i;

  // Misaligned and non-memory ops are complete on arrival and never reach the bus.
  assign acc_mis = in_mem_i && misaligned(in_op_i[1:0], in_addr_i[1:0]);
  always_comb begin
    acc_excp = '0;
    if (acc_mis) begin
      if (in_op_i[OP_STORE]) acc_excp[EXCP_ST_MIS] = 1'b1;
      else                   acc_excp[EXCP_LD_MIS] = 1'b1;
    end
    acc_data = (!in_mem_i || (in_op_i[OP_STORE] && !acc_mis)) ? in_data_i : '0;
  end

  assign iss_pend    = iss_q != tail_q;
  assign iss_skip    = iss_pend && st_q[iidx] == DONE;
  // Stale responses from before a flush must drain before any new request goes out.
  assign req_valid_o = active_q && drain_q == '0 && iss_pend && st_q[iidx] == WAIT_REQ;
  assign req_fire    = req_valid_o && req_ready_i;

  assign req_addr_o  = req_valid_o ? {ent_q[iidx].addr[XLEN-1:2], 2'b00} : '0;
  assign req_we_o    = req_valid_o && ent_q[iidx].op[OP_STORE];
  assign req_wdata_o = req_we_o ? ent_q[iidx].data << {ent_q[iidx].addr[1:0], 3'b000} : '0;
  assign req_wstrb_o = req_we_o ? size_mask(ent_q[iidx].op[1:0]) << ent_q[iidx].addr[1:0] : '0;

  always_comb begin
    rsp_hit = 1'b0;
    rsp_idx = '0;
    nwait   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!rsp_hit && (PW'(k) < cnt) && st_q[hidx + AW'(k)] == WAIT_RESP) begin
        rsp_hit = 1'b1;
        rsp_idx = hidx + AW'(k);
      end
      if (st_q[k] == WAIT_RESP) nwait = nwait + PW'(1);
    end
  end

  assign resp_fire = resp_valid_i && resp_ready_o;
  assign drop      = resp_fire && drain_q != '0;
  assign rsp_done  = resp_fire && drain_q == '0 && rsp_hit;
  assign resp_used = drop || rsp_done;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (resp_rdata_i),
    .off    (ent_q[rsp_idx].addr[1:0]),
    .op     (ent_q[rsp_idx].op),
    .result (ld_result)
  );

  assign out_valid_o   = (head_q != tail_q) && st_q[hidx] == DONE;
  assign out_payload_o = out_valid_o ? pay_q[hidx] : '0;
  assign out_result_o  = out_valid_o ? ent_q[hidx].data : '0;
  assign out_excp_o    = out_valid_o ? ent_q[hidx].excp : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      iss_q    <= '0;
      tail_q   <= '0;
      drain_q  <= '0;
      active_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) st_q[k] <= DONE;
    end else begin
      active_q <= 1'b1;
      if (flush_i) begin
        head_q  <= '0;
        iss_q   <= '0;
        tail_q  <= '0;
        // Everything already on the bus (including a same-cycle handshake) must be drained.
        drain_q <= drain_q + nwait + PW'(req_fire) - PW'(resp_used);
        for (int k = 0; k < DEPTH; k++) st_q[k] <= DONE;
      end else begin
        if (drop) drain_q <= drain_q - PW'(1);
        if (accept) begin
          st_q[tidx] <= (!in_mem_i || acc_mis) ? DONE : WAIT_REQ;
          tail_q     <= tail_q + PW'(1);
        end
        if (req_fire) begin
          st_q[iidx] <= WAIT_RESP;
          iss_q      <= iss_q + PW'(1);
        end else if (iss_skip) begin
          iss_q <= iss_q + PW'(1);
        end
        if (rsp_done) st_q[rsp_idx] <= DONE;
        if (out_valid_o && out_ready_i) head_q <= head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      ent_q[tidx] <= '{op: in_op_i, addr: in_addr_i, data: acc_data, excp: acc_excp};
      pay_q[tidx] <= in_payload_i;
    end
    if (rsp_done) begin
      if (ent_q[rsp_idx].op[OP_STORE]) begin
        ent_q[rsp_idx].data                <= '0;
        ent_q[rsp_idx].excp[EXCP_ST_FAULT] <= resp_err_i[RESP_FAULT];
      end else begin
        ent_q[rsp_idx].data                <= ld_result;
        ent_q[rsp_idx].excp[EXCP_LD_FAULT] <= resp_err_i[RESP_FAULT];
      end
    end
  end

`ifdef LSU_OQ_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_load_o  <= '0;
      perf_store_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (rsp_done && !flush_i) begin
        if (ent_q[rsp_idx].op[OP_STORE]) perf_store_o <= perf_store_o + 32'd1;
        else                             perf_load_o  <= perf_load_o + 32'd1;
      end
      if (req_valid_o && !req_ready_i) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
